// File: rtl/mdio_target.sv
// MDIO management target: samples MDC rises on clk, decodes 32-bit frames, serves a 32x16 register file.
// Define MDIO_TARGET_PREAMBLE_EN to require 32 consecutive 1s of preamble before each start of frame.
module mdio_target #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_valid,
  output logic        busy
);

  // In the preamble build S_IDLE doubles as the preamble hunt state.
  typedef enum logic [2:0] {
    S_IDLE, S_ST1, S_HDR, S_TA_RD, S_TX, S_TA_WR, S_RX, S_SKIP
  } state_t;

  state_t      state, state_n;
  logic        mdc_q, rise;
  logic [4:0]  bitn, bitn_n;
  logic [11:0] hdr, hdr_n;
  logic [4:0]  regad, regad_n;
  logic [15:0] sh, sh_n;
  logic        out_n, oe_n, wr_v_n, rd_v_n, busy_n, commit;
  logic [4:0]  wr_addr_n;
  logic [15:0] wr_data_n;
  logic [15:0] regs [32];
`ifdef MDIO_TARGET_PREAMBLE_EN
  logic [5:0]  pre_cnt, pre_n;
`endif

  assign rise = mdc & ~mdc_q;

  always_comb begin
    state_n   = state;
    bitn_n    = bitn;
    hdr_n     = hdr;
    regad_n   = regad;
    sh_n      = sh;
    out_n     = mdio_out;
    oe_n      = mdio_oe;
    wr_v_n    = 1'b0;
    rd_v_n    = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    commit    = 1'b0;
`ifdef MDIO_TARGET_PREAMBLE_EN
    pre_n     = pre_cnt;
`endif
    if (rise) begin
      bitn_n = bitn + 5'd1;
      case (state)
        S_IDLE: begin
`ifdef MDIO_TARGET_PREAMBLE_EN
          if (mdio_in) begin
            pre_n = (pre_cnt == 6'd32) ? pre_cnt : pre_cnt + 6'd1;
          end else begin
            if (pre_cnt == 6'd32) state_n = S_ST1;
            pre_n = '0;
          end
`else
          if (!mdio_in) state_n = S_ST1;
`endif
        end
        S_ST1: begin
          if (mdio_in) begin
            state_n = S_HDR;
            bitn_n  = 5'd2;
          end
        end
        S_HDR: begin
          hdr_n = {hdr[10:0], mdio_in};
          if (bitn == 5'd13) begin
            // hdr_n = {OP[1:0], PHYAD[4:0], REGAD[4:0]}; read data is snapshotted here
            regad_n = hdr_n[4:0];
            sh_n    = regs[hdr_n[4:0]];
            if (hdr_n[9:5] != PHY_ADDR)  state_n = S_SKIP;
            else if (hdr_n[11:10] == 2'b10) state_n = S_TA_RD;
            else if (hdr_n[11:10] == 2'b01) state_n = S_TA_WR;
            else                          state_n = S_SKIP;
          end
        end
        S_TA_RD: begin
          if (bitn == 5'd14) begin
            oe_n  = 1'b1;
            out_n = 1'b0;
          end else begin
            out_n   = sh[15];
            sh_n    = {sh[14:0], 1'b0};
            state_n = S_TX;
          end
        end
        S_TX: begin
          if (bitn == 5'd31) begin
            oe_n    = 1'b0;
            out_n   = 1'b0;
            rd_v_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            out_n = sh[15];
            sh_n  = {sh[14:0], 1'b0};
          end
        end
        S_TA_WR: begin
          if (bitn == 5'd15) state_n = S_RX;
        end
        S_RX: begin
          sh_n = {sh[14:0], mdio_in};
          if (bitn == 5'd31) begin
            commit    = 1'b1;
            wr_addr_n = regad;
            wr_data_n = sh_n;
            wr_v_n    = 1'b1;
            state_n   = S_IDLE;
          end
        end
        S_SKIP: begin
          if (bitn == 5'd31) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
    busy_n = (state_n != S_IDLE) && (state_n != S_ST1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_q    <= 1'b0;
      state    <= S_IDLE;
      bitn     <= '0;
      hdr      <= '0;
      regad    <= '0;
      sh       <= '0;
      mdio_out <= 1'b0;
      mdio_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef MDIO_TARGET_PREAMBLE_EN
      pre_cnt  <= '0;
`endif
    end else begin
      mdc_q    <= mdc;
      state    <= state_n;
      bitn     <= bitn_n;
      hdr      <= hdr_n;
      regad    <= regad_n;
      sh       <= sh_n;
      mdio_out <= out_n;
      mdio_oe  <= oe_n;
      wr_valid <= wr_v_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      rd_valid <= rd_v_n;
      busy     <= busy_n;
`ifdef MDIO_TARGET_PREAMBLE_EN
      pre_cnt  <= pre_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[regad] <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_mdio_target.sv
// Scoreboarded bench for mdio_target: a bit-level MDIO generator drives frames, a monitor checks commits and reads.
module tb_mdio_target;

  logic        clk = 1'b0;
  logic        reset, mdc, mdio_in;
  logic        mdio_out, mdio_oe, wr_valid, rd_valid, busy;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int total = 0;
  int bad   = 0;

`ifdef MDIO_TARGET_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif

  logic [15:0] model_regs [32];
  logic [20:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] rdw;
  logic        ta;

  mdio_target #(.PHY_ADDR(5'd1)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] phy,
                                     input logic [4:0] ra, input logic [15:0] d);
    return {2'b01, op, phy, ra, 2'b10, d};
  endfunction

  // One MDC period: low two clk, then a rise held high two clk.
  task automatic bit_cycle(input logic b);
    @(negedge clk);
    mdc = 1'b0;
    mdio_in = b;
    repeat (2) @(negedge clk);
    mdc = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) bit_cycle(1'b1);
  endtask

  // Drives one frame like the generator; abort_at >= 0 asserts reset after that bit's rise.
  task automatic send(input logic [31:0] f, input int pre, input int abort_at);
    logic [1:0]  op;
    logic [4:0]  phy, ra;
    logic        acc, is_rd, is_wr;
    int          errs;
    op    = f[29:28];
    phy   = f[27:23];
    ra    = f[22:18];
    acc   = (pre >= 32) || (PRE == 0);
    is_rd = acc && phy == 5'd1 && op == 2'b10;
    is_wr = acc && phy == 5'd1 && op == 2'b01;
    if (abort_at < 0) begin
      if (is_wr) begin
        model_regs[ra] = f[15:0];
        wr_q.push_back({ra, f[15:0]});
      end
      if (is_rd) rd_q.push_back(model_regs[ra]);
    end
    for (int i = 0; i < pre; i++) bit_cycle(1'b1);
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      mdc = 1'b0;
      mdio_in = (is_rd && i >= 14) ? 1'b1 : f[31-i];
      repeat (2) @(negedge clk);
      // generator samples the bus at its own MDC rise
      if (mdio_oe !== (is_rd && i >= 15)) errs++;
      if (busy !== (acc && i >= 2)) errs++;
      if (is_rd && i == 15) ta = mdio_out;
      if (is_rd && i >= 16) rdw = {rdw[14:0], mdio_out};
      mdc = 1'b1;
      repeat (2) @(negedge clk);
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_oe", {31'd0, mdio_oe}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mdc = 1'b0;
        mdio_in = 1'b1;
        for (int r = 0; r < 32; r++) model_regs[r] = 16'h0000;
        return;
      end
    end
    if (busy !== 1'b0) errs++;
    if (mdio_oe !== 1'b0) errs++;
    check("frame_trace", errs, 32'd0);
    if (is_rd) check("ta_bit2", {31'd0, ta}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (wr_valid) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_commit", {11'd0, wr_addr, wr_data}, {11'd0, wr_q.pop_front()});
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_data", {16'd0, rdw}, {16'd0, rd_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [4:0]  phy, ra;
    for (int r = 0; r < 32; r++) model_regs[r] = 16'h0000;
    reset = 1'b1;
    mdc = 1'b0;
    mdio_in = 1'b1;
    rdw = '0;
    ta = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {6'd0, mdio_out, mdio_oe, wr_valid, wr_addr, wr_data, rd_valid, busy}, 32'd0);
    reset = 1'b0;
    idle_bits(2);

    send(mk(2'b01, 5'd1, 5'd5, 16'hBEEF), PRE, -1);
    idle_bits(1);
    send(mk(2'b10, 5'd1, 5'd5, 16'h0000), PRE, -1);
    idle_bits(1);
    send(mk(2'b01, 5'd2, 5'd5, 16'h1234), PRE, -1);
    send(mk(2'b10, 5'd1, 5'd5, 16'h0000), PRE, -1);
    send(mk(2'b11, 5'd1, 5'd5, 16'hA5A5), PRE, -1);
    send(mk(2'b10, 5'd1, 5'd5, 16'h0000), PRE, -1);

    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd1;
      ra  = 5'($urandom_range(0, 7));
      send(mk(op, phy, ra, 16'($urandom)), PRE, -1);
      idle_bits(int'($urandom_range(0, 2)));
    end

    send(mk(2'b10, 5'd1, 5'd5, 16'h0000), PRE, 20);
    idle_bits(2);
    send(mk(2'b10, 5'd1, 5'd5, 16'h0000), PRE, -1);
    send(mk(2'b01, 5'd1, 5'd9, 16'h0F0F), PRE, -1);
    send(mk(2'b10, 5'd1, 5'd9, 16'h0000), PRE, -1);

`ifdef MDIO_TARGET_PREAMBLE_EN
    send(mk(2'b01, 5'd1, 5'd9, 16'h7777), 31, -1);
    idle_bits(1);
    send(mk(2'b10, 5'd1, 5'd9, 16'h0000), 32, -1);
`endif

    repeat (10) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
